// File: rtl/seq_restoring_div.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SIGNED_DIV_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module seq_restoring_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   dvd_abs, dsr_abs;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef SIGNED_DIV_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  // Magnitudes feed the unsigned core; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    dvd_abs = dividend[WIDTH-1] ? WIDTH'(~dividend + 1'b1) : dividend;
    dsr_abs = divisor[WIDTH-1]  ? WIDTH'(~divisor + 1'b1)  : divisor;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (state_q == IDLE && in_valid && in_ready_q) begin
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  always_comb begin
    dvd_abs = dividend;
    dsr_abs = divisor;
  end
`endif

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    quo_fix     = '0;
    rem_fix     = '0;
    trial       = {prem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          quo_d  = dvd_abs;
          dsr_d  = dsr_abs;
          prem_d = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          prem_d = trial[WIDTH-1:0];
        end else begin
          prem_d = {prem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
`ifdef SIGNED_DIV_EN
          quo_fix = q_neg_q ? WIDTH'(~quo_d + 1'b1) : quo_d;
          rem_fix = r_neg_q ? WIDTH'(~prem_d + 1'b1) : prem_d;
`else
          quo_fix = quo_d;
          rem_fix = prem_d;
`endif
          state_d     = DONE;
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed self-checking bench for seq_restoring_div (WIDTH=8), unsigned or SIGNED_DIV_EN build.
module tb_seq_restoring_div;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands for one accept edge, then scramble them to show they are not re-read.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = b + 8'd3;
  endtask

  // Edges counted from the accept edge (=1) until out_valid is seen.
  task automatic wait_result(input int exp_lat);
    int n;
    logic bad_ready;
    n = 1;
    bad_ready = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad_ready = 1'b1;
      step();
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("in_ready_low_busy", 32'(bad_ready | in_ready), 32'd0);
  endtask

  task automatic check_res(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic z);
    check("quotient", 32'(quotient), 32'(q));
    check("remainder", 32'(remainder), 32'(r));
    check("div_by_zero", 32'(div_by_zero), 32'(z));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_pop", 32'(out_valid), 32'd0);
    check("in_ready_after_pop", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                     input logic z, input int lat);
    launch(a, b);
    wait_result(lat);
    check_res(q, r, z);
    pop();
  endtask

  initial begin
    logic saw_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_res(8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step();

    // Divide by zero: one-edge latency, all-ones quotient, dividend as remainder.
    run(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);

`ifdef SIGNED_DIV_EN
    run(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, WIDTH + 1);
    run(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, WIDTH + 1);
    run(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, WIDTH + 1);
    run(8'hF9, 8'd0, 8'hFF, 8'hF9, 1'b1, 1);
`else
    run(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, WIDTH + 1);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, WIDTH + 1);
    run(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, WIDTH + 1);
    run(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, WIDTH + 1);
`endif

    // Backpressure: result held while out_ready is low and new operands are refused.
    launch(8'd50, 8'd5);
    wait_result(WIDTH + 1);
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check_res(8'd10, 8'd0, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_outputs_held", 32'(quotient), 32'd10);
    run(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, WIDTH + 1);

    // Reset mid-operation abandons the division.
    launch(8'd200, 8'd7);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check_res(8'd0, 8'd0, 1'b0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_stale", 32'(saw_valid), 32'd0);
    run(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, WIDTH + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
